// File: rtl/data_mem_lsu.sv
// -----------------------------------------------------------------------------
// data_mem_lsu
//
// Load/store unit between the core's MEM stage and a word-only data SRAM
// (combinational read, posedge write). Byte/half/word loads and stores are
// translated into SRAM word accesses. Sub-word stores use read-modify-write.
// Loads are sign- or zero-extended. Byte order is little-endian.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests skip the SRAM and complete in one
//               cycle with resp_err=1 and resp_rdata=0.
//   undefined : misaligned low address bits are ignored (half: addr[0],
//               word: addr[1:0]); resp_err is tied 0.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid / req_ready      request handshake (accept on posedge when both high)
//   req_we                     1 = store, 0 = load
//   req_size                   00 byte, 01 half, 10/11 word
//   req_unsigned               loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata        byte address, right-justified store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata                 extended load data (0 for stores)
//   resp_err                   misalignment flag (trap build only)
//   mem_addr, mem_we, mem_wd   SRAM word address, write enable, write data
//   mem_rd                     SRAM read data (combinational from mem_addr)
// -----------------------------------------------------------------------------
module data_mem_lsu #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int          AW        = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic            we_q, we_d;
    logic            uns_q, uns_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     wd_q, wd_d;
    logic [31:0]     rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            err_q, err_d;
    logic            req_misaligned;
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [AW-1:0] req_idx;
    logic [1:0]    req_size_n;
    logic [1:0]    req_lane_n;

    // Window offset; bits above the SRAM range are dropped so addresses
    // outside the window alias onto it.
    assign req_idx    = AW'((req_addr - BASE_ADDR) >> 2);
    assign req_size_n = (req_size == 2'b11) ? SZ_WORD : req_size;

    // Lane with the low bits that the access size cannot use forced to 0.
    always_comb begin
        req_lane_n = req_addr[1:0];
        if (req_size_n == SZ_HALF) begin
            req_lane_n = {req_addr[1], 1'b0};
        end else if (req_size_n == SZ_WORD) begin
            req_lane_n = 2'b00;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misaligned = ((req_size_n == SZ_HALF) && req_addr[0]) ||
                            ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
`endif

    // ------------------------------------------------------------------
    // Byte-lane datapath: store-data replication, RMW merge, load extract
    // ------------------------------------------------------------------
    logic [31:0] wdata_rep;
    logic [3:0]  byte_en;
    logic [31:0] merged_word;
    logic [7:0]  rd_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    // Replicate the right-justified store data across every lane so each
    // enabled lane simply picks its own slice.
    always_comb begin
        case (size_q)
            SZ_BYTE: wdata_rep = {4{wdata_q[7:0]}};
            SZ_HALF: wdata_rep = {2{wdata_q[15:0]}};
            default: wdata_rep = wdata_q;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            assign rd_bytes[gi] = mem_rd[gi*8 +: 8];
            assign byte_en[gi]  = (size_q == SZ_BYTE) ? (lane_q == 2'(gi)) :
                                  (size_q == SZ_HALF) ? (lane_q[1] == 1'(gi >> 1)) :
                                  1'b1;
            assign merged_word[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8]
                                                        : rd_bytes[gi];
        end
    endgenerate

    assign sel_byte = rd_bytes[lane_q];
    assign sel_half = lane_q[1] ? mem_rd[31:16] : mem_rd[15:0];

    always_comb begin
        case (size_q)
            SZ_BYTE: load_ext = {{24{~uns_q & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_ext = {{16{~uns_q & sel_half[15]}}, sel_half};
            default: load_ext = mem_rd;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lane_d  = req_lane_n;
                    size_d  = req_size_n;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d   = 1'b0;
                    if (req_misaligned) begin
                        // No SRAM access at all: the address register keeps
                        // its previous value.
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else
`endif
                    begin
                        addr_d = req_idx;
                        if (req_we && (req_size_n == SZ_WORD)) begin
                            wd_d    = req_wdata;
                            state_d = S_WR;
                        end else begin
                            // Loads and sub-word stores both read first.
                            state_d = S_RD;
                        end
                    end
                end
            end

            S_RD: begin
                if (we_q) begin
                    wd_d    = merged_word;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end
            end

            S_WR: begin
                state_d = S_RESP;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lane_q  <= 2'b00;
            size_q  <= SZ_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            wd_q    <= 32'h0;
            rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    // Decoded straight from the state so an asynchronous reset during WR
    // removes the write enable before the next edge.
    assign mem_we     = (state_q == S_WR);
    assign mem_addr   = addr_q;
    assign mem_wd     = wd_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_err   = resp_valid & err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
